// File: rtl/core_pkg.sv
// Shared core definitions: branch-history counter encoding and table sizing defaults.
package core_pkg;

  typedef logic [1:0] bht_state_t;

  localparam bht_state_t BHT_SNT = 2'b00;
  localparam bht_state_t BHT_WNT = 2'b01;
  localparam bht_state_t BHT_WT  = 2'b10;
  localparam bht_state_t BHT_ST  = 2'b11;

  // Counter value reported on a lookup miss; a branch allocated later starts from this.
  localparam bht_state_t BHT_MISS_STATE = BHT_WNT;

  localparam int BHT_INDEX_BITS = 6;

endpackage : core_pkg

// File: rtl/bht_next_state.sv
// Saturating 2-bit up/down counter step: taken moves toward strong-taken,
// not-taken moves toward strong-not-taken, clamping at both ends.
module bht_next_state
  import core_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);

  // Step the counter one position in the direction of the outcome.
  always_comb begin
    next = state;
    if (taken) begin
      if (state != BHT_ST) next = state + 2'd1;
    end else begin
      if (state != BHT_SNT) next = state - 2'd1;
    end
  end

endmodule : bht_next_state

// File: rtl/bht_unit.sv
// Direct-mapped branch history table. Zero-latency lookup for fetch, trained
// from EX using the counter state that travelled with the branch, plus
// saturating branch / mispredict performance counters.
module bht_unit
  import core_pkg::*;
#(
  parameter int INDEX_BITS = BHT_INDEX_BITS,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic [1:0]      pred_state,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [1:0]      upd_state,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispred
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_W - INDEX_BITS - 2;

  // Table lives in flops so it can be cleared asynchronously and read with no latency.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic                  mispredict;
  logic [1:0]            upd_next;

  // PC bits [1:0] never select an entry; instructions are word aligned.
  logic unused_pc_low;
  assign unused_pc_low = ^{if_pc[1:0], upd_pc[1:0]};

  assign lk_idx  = if_pc[INDEX_BITS+1:2];
  assign lk_tag  = if_pc[PC_W-1:INDEX_BITS+2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[PC_W-1:INDEX_BITS+2];

  // Fetch-side lookup; reads the registered table only, so a same-cycle update is not visible.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_state  = pred_hit ? ctr_q[lk_idx] : BHT_MISS_STATE;
    pred_target = pred_hit ? target_q[lk_idx] : '0;
    pred_taken  = pred_hit & pred_state[1];
  end

  // EX-side hit detection against the entry the resolving branch maps to.
  always_comb begin
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    mispredict = upd_en && (upd_taken != upd_state[1]);
  end

  // The next counter comes from the state carried down the pipe, not from a table re-read,
  // so an intervening update to the same entry does not get counted twice.
  bht_next_state u_next_state (
    .state (upd_state),
    .taken (upd_taken),
    .next  (upd_next)
  );

  // Train or allocate the indexed entry; not-taken misses leave the table alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BHT_WNT;
      end
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_next;
        if (upd_taken) target_q[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= BHT_WT;
      end
    end
  end

  // Saturating performance counters; they hold at all-ones rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      if (upd_en && (perf_branches != '1)) perf_branches <= perf_branches + 32'd1;
      if (mispredict && (perf_mispred != '1)) perf_mispred <= perf_mispred + 32'd1;
    end
  end

endmodule : bht_unit

// File: tb/tb_bht_unit.sv
// Directed bench for bht_unit: stimulus queues the expected lookup/perf view,
// a separate monitor pops and compares each one on the falling edge.
module tb_bht_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_state;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [1:0]  upd_state;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] perf_branches;
  logic [31:0] perf_mispred;

  bht_unit #(.INDEX_BITS(6), .PC_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_state    (pred_state),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_state     (upd_state),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .perf_branches (perf_branches),
    .perf_mispred  (perf_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  state;
    logic [31:0] branches;
    logic [31:0] mispred;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", name, field, act, exp);
    end
  endtask

  // Monitor: every falling edge, compare the DUT against all queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp(e.name, "hit",      {31'd0, pred_hit},   {31'd0, e.hit});
        cmp(e.name, "taken",    {31'd0, pred_taken}, {31'd0, e.taken});
        cmp(e.name, "target",   pred_target,         e.target);
        cmp(e.name, "state",    {30'd0, pred_state}, {30'd0, e.state});
        cmp(e.name, "branches", perf_branches,       e.branches);
        cmp(e.name, "mispred",  perf_mispred,        e.mispred);
      end
    end
  end

  task automatic expect_view(input string name, input logic hit, input logic taken,
                             input logic [31:0] target, input logic [1:0] state,
                             input logic [31:0] br, input logic [31:0] mp);
    exp_t e;
    e.name = name; e.hit = hit; e.taken = taken; e.target = target;
    e.state = state; e.branches = br; e.mispred = mp;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic en, input logic [31:0] pc, input logic [1:0] st,
                         input logic tk, input logic [31:0] tgt);
    upd_en = en; upd_pc = pc; upd_state = st; upd_taken = tk; upd_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h100;
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    expect_view("reset", 0, 0, 32'h0, 2'b01, 0, 0);

    // allocate 0x100: same cycle still misses, next cycle hits weak-taken
    step();
    set_upd(1'b1, 32'h100, 2'b01, 1'b1, 32'h200);
    expect_view("alloc_same_cycle", 0, 0, 32'h0, 2'b01, 0, 0);
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    expect_view("alloc_visible", 1, 1, 32'h200, 2'b10, 1, 1);

    // four taken updates carrying strong-taken saturate at 11
    for (int i = 0; i < 4; i++) begin
      step();
      set_upd(1'b1, 32'h100, 2'b11, 1'b1, 32'h200);
    end
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    expect_view("sat_high", 1, 1, 32'h200, 2'b11, 5, 1);

    // not-taken from strong-taken: down to weak-taken, counted as mispredict
    step();
    set_upd(1'b1, 32'h100, 2'b11, 1'b0, 32'h999);
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    expect_view("nt_from_st", 1, 1, 32'h200, 2'b10, 6, 2);

    // not-taken miss at 0x300 (same index 0 as 0x100) leaves the entry alone
    step();
    set_upd(1'b1, 32'h300, 2'b01, 1'b0, 32'h777);
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    if_pc = 32'h300;
    expect_view("nt_miss_0x300", 0, 0, 32'h0, 2'b01, 7, 2);
    step();
    if_pc = 32'h100;
    expect_view("nt_miss_entry_kept", 1, 1, 32'h200, 2'b10, 7, 2);

    // aliasing: 0x200 shares index 0, different tag, replaces the entry
    step();
    set_upd(1'b1, 32'h200, 2'b01, 1'b1, 32'h400);
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    expect_view("alias_old_misses", 0, 0, 32'h0, 2'b01, 8, 3);
    step();
    if_pc = 32'h200;
    expect_view("alias_new_hits", 1, 1, 32'h400, 2'b10, 8, 3);

    // reallocate 0x100, then same-cycle lookup + update: old contents, then new
    step();
    if_pc = 32'h100;
    set_upd(1'b1, 32'h100, 2'b01, 1'b1, 32'h200);
    step();
    set_upd(1'b1, 32'h100, 2'b10, 1'b1, 32'h240);
    expect_view("same_cycle_old", 1, 1, 32'h200, 2'b10, 9, 4);
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    expect_view("same_cycle_new", 1, 1, 32'h240, 2'b11, 10, 4);

    // low saturation: not-taken carrying 00 stays 00; target kept
    step();
    set_upd(1'b1, 32'h100, 2'b00, 1'b0, 32'h888);
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    expect_view("sat_low", 1, 0, 32'h240, 2'b00, 11, 4);

    // asynchronous reset mid-update: outputs clear at once, update discarded
    step();
    set_upd(1'b1, 32'h100, 2'b11, 1'b1, 32'h500);
    rst_n = 1'b0;
    expect_view("async_reset", 0, 0, 32'h0, 2'b01, 0, 0);
    step();
    set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    rst_n = 1'b1;
    expect_view("after_reset", 0, 0, 32'h0, 2'b01, 0, 0);

    step();
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bht_unit

// File: doc/bht_unit.md
# bht_unit

Branch history table feeding the fetch stage and trained by the execute stage. Performs a combinational lookup on the fetch PC, producing a taken/not-taken prediction, a target and the 2-bit counter state that travels down the pipeline registers as `bht_state`. When the branch resolves in EX, the carried state and outcome come back to this block, which updates the entry and the performance counters.

## Interface
- `INDEX_BITS`, 6: table has 2^INDEX_BITS direct-mapped entries.
- `PC_W`, 32: PC width; tag = `PC_W-INDEX_BITS-2` bits.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_pc` in PC_W: fetch-stage PC.
- `pred_hit` out 1: valid entry with matching tag.
- `pred_taken` out 1: `pred_hit & pred_state[1]`.
- `pred_target` out PC_W: stored target on hit, else 0.
- `pred_state` out 2: counter on hit, else 2'b01.
- `upd_en` in 1: EX resolves a branch this cycle (already qualified by is_branch and pipeline enable).
- `upd_pc` in PC_W: PC of the resolving branch.
- `upd_state` in 2: `bht_state` carried with that branch.
- `upd_taken` in 1: actual outcome.
- `upd_target` in PC_W: actual target.
- `perf_branches` out 32: resolved branch count.
- `perf_mispred` out 32: direction mispredict count.

## Operation
- Index = `pc[INDEX_BITS+1:2]`; tag = `pc[PC_W-1:INDEX_BITS+2]`.
- Entry fields: valid, tag, target, 2-bit counter. Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup: purely combinational from `if_pc` and table contents.
- Update (on `upd_en`, at clk edge), entry at `upd_pc` index:
  - Tag match and valid: counter <= sat(upd_state ± 1) (+1 taken, −1 not taken; saturate at 00/11). Target <= `upd_target` only when taken.
  - Miss, taken: allocate/replace: valid=1, tag, target=`upd_target`, counter=2'b10.
  - Miss, not taken: entry unchanged.
- Next counter is computed from `upd_state`, never from a re-read of the table.
- Mispredict = `upd_en & (upd_taken != upd_state[1])`.
- `perf_branches` += 1 per `upd_en`; `perf_mispred` += 1 per mispredict; both saturate at all-ones.

## Timing
- Lookup latency 0 cycles; an update becomes visible to lookup the cycle after the write edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass).
- At most one update per cycle; no handshake and no backpressure.
- Reset (asynchronous, any time, including mid-update): all valid=0, counters=01, tags/targets=0, perf counters=0. Hence `pred_hit`=0, `pred_taken`=0, `pred_target`=0, `pred_state`=01.
- An update in flight when reset asserts is discarded.

## Structure
- Shared package `core_pkg`: state constants `BHT_SNT`/`BHT_WNT`/`BHT_WT`/`BHT_ST`, `BHT_MISS_STATE` (=`BHT_WNT`), and the default `INDEX_BITS`.
- One sub-module: `bht_next_state`, a combinational saturating 2-bit up/down counter (state, taken -> next).
- Table is implemented in flops, not RAM, because of the asynchronous reset and zero-latency lookup.

## Test plan
- After reset, `if_pc`=0x100 -> `pred_hit`=0, `pred_state`=01, `pred_taken`=0, both perf counters 0.
- Update pc=0x100, state=01, taken, target=0x200; next cycle lookup 0x100 -> hit, state=10, taken, target=0x200; `perf_mispred`=1.
- Four taken updates carrying state 11 -> state stays 11; then one not-taken update with state 11 -> 10, `perf_mispred`+1.
- Not-taken update on a miss at 0x300 -> lookup 0x300 still misses, and entry index (0x300>>2)&63 is unchanged.
- Aliasing: allocate 0x100 taken, then update 0x100+256 (same index, different tag) taken target 0x400 -> 0x100 misses, and the new PC hits with state 10.
- Same-cycle lookup and update at 0x100 -> lookup shows the old state that cycle and the new one next cycle. Assert `rst_n` mid-sequence -> all outputs return to their reset values immediately.
